counter_arbiter: RTL and testbench

COUNTER_ARBITER -- requirements
Module: counter_arbiter

---
 rtl/counter_arbiter.sv | 90 +++++++++
 tb/tb_counter_arbiter.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/counter_arbiter.sv
// counter_arbiter: round-robin arbiter that hands a shared counter FSM to one requester at a time
module counter_arbiter #(
    parameter int CNT_WIDTH = 8,
    parameter int NUM_REQ   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_i,
    input  logic [NUM_REQ*CNT_WIDTH-1:0] cnt_val_i,
    output logic [NUM_REQ-1:0]           gnt_o,
    output logic [NUM_REQ-1:0]           ack_o,
    output logic                         busy_o,
    output logic                         start_o,
    output logic [CNT_WIDTH-1:0]         cnt_val_o,
    input  logic                         cnt_idle_i,
    input  logic                         cnt_done_i
);
    localparam int IW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RELEASE} state_t;

    state_t                 state_q, state_d;
    logic [IW-1:0]          owner_q, owner_d, last_q, last_d, win, idx;
    logic [CNT_WIDTH-1:0]   val_q, val_d;
    logic                   found;
    logic [CNT_WIDTH-1:0]   slice [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign slice[g] = cnt_val_i[g*CNT_WIDTH +: CNT_WIDTH];
    end

    // first requester scanning upward from the one after the last owner
    always_comb begin
        win   = last_q;
        idx   = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = IW'((int'(last_q) + i) % NUM_REQ);
            if (!found && req_i[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // state, owner, latched target and last owner registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IW'(NUM_REQ - 1);
            val_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            val_q   <= val_d;
        end
    end

    // next state; target is captured once at grant so later input changes are ignored
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        val_d   = val_q;
        case (state_q)
            IDLE: if (found && cnt_idle_i) begin
                state_d = LAUNCH;
                owner_d = win;
                val_d   = slice[win];
            end
            LAUNCH:  state_d = (val_q != '0) ? WAIT : RELEASE;
            WAIT:    state_d = cnt_done_i ? RELEASE : WAIT;
            default: begin
                state_d = IDLE;
                last_d  = owner_q;
            end
        endcase
    end

    // outputs decoded purely from registered state
    always_comb begin
        gnt_o     = (state_q != IDLE) ? NUM_REQ'(1) << owner_q : '0;
        ack_o     = (state_q == RELEASE) ? NUM_REQ'(1) << owner_q : '0;
        start_o   = (state_q == LAUNCH) && (val_q != '0);
        busy_o    = state_q != IDLE;
        cnt_val_o = val_q;
    end
endmodule

// File: tb/tb_counter_arbiter.sv
// tb_counter_arbiter: scoreboard bench with a transaction-level arbitration model
module tb_counter_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_i = '0;
    logic [N*W-1:0] cnt_val_i = '0;
    logic           cnt_idle_i = 1'b0;
    logic           cnt_done_i = 1'b0;
    logic [N-1:0]   gnt_o, ack_o;
    logic           busy_o, start_o;
    logic [W-1:0]   cnt_val_o;

    counter_arbiter #(.CNT_WIDTH(W), .NUM_REQ(N)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .cnt_val_i(cnt_val_i),
        .gnt_o(gnt_o), .ack_o(ack_o), .busy_o(busy_o), .start_o(start_o),
        .cnt_val_o(cnt_val_o), .cnt_idle_i(cnt_idle_i), .cnt_done_i(cnt_done_i)
    );

    always #5 clk = ~clk;

    typedef struct { int owner; logic [W-1:0] val; } job_t;
    typedef struct { int owner; int due; } ack_t;

    job_t         grant_q[$];
    ack_t         ack_q[$];
    int           errors = 0;
    int           checks = 0;
    int           cyc = 0;
    int           last = N - 1;
    logic [N-1:0] prev_gnt = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pick(input logic [N-1:0] mask, input int from);
        for (int i = 1; i <= N; i++)
            if (mask[(from + i) % N]) return (from + i) % N;
        return -1;
    endfunction

    // monitor: pops expectations whenever the DUT presents a grant or an ack
    always @(negedge clk) begin
        job_t j;
        ack_t a;
        if (!rst_n) prev_gnt = '0;
        else begin
            if (gnt_o != '0 && prev_gnt == '0) begin
                if (grant_q.size() == 0) check("unexpected_grant", 64'(gnt_o), 64'(0));
                else begin
                    j = grant_q.pop_front();
                    check("gnt", 64'(gnt_o), 64'(1) << j.owner);
                    check("cnt_val", 64'(cnt_val_o), 64'(j.val));
                    check("start", 64'(start_o), 64'(j.val != '0));
                    check("busy", 64'(busy_o), 64'(1));
                end
            end else if (start_o) check("stray_start", 64'(start_o), 64'(0));
            if (ack_o != '0) begin
                if (ack_q.size() == 0) check("unexpected_ack", 64'(ack_o), 64'(0));
                else begin
                    a = ack_q.pop_front();
                    check("ack", 64'(ack_o), 64'(1) << a.owner);
                    check("ack_cycle", 64'(cyc), 64'(a.due));
                end
            end
            prev_gnt = gnt_o;
        end
    end

    // one complete job, entered and left on a falling edge; returns the granted index
    task automatic run_job(input logic [N-1:0] mask, input logic [N*W-1:0] vals,
                           input int idle_wait, input bit drop, output int owner);
        job_t j;
        int   t = 0;
        owner      = pick(mask, last);
        j.owner    = owner;
        j.val      = vals[owner*W +: W];
        grant_q.push_back(j);
        req_i      = mask;
        cnt_val_i  = vals;
        cnt_idle_i = (idle_wait == 0);
        for (int k = 0; k < idle_wait; k++) begin
            cnt_done_i = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("gnt_while_cnt_busy", 64'(gnt_o), 64'(0));
        end
        cnt_done_i = 1'b0;
        cnt_idle_i = 1'b1;
        do begin
            @(negedge clk);
            t++;
        end while (gnt_o == '0 && t < 20);
        check("grant_timeout", 64'(gnt_o != '0), 64'(1));
        if (gnt_o == '0) return;
        cnt_val_i  = N*W'($urandom());
        cnt_done_i = 1'b1;
        if (drop) req_i = '0;
        if (j.val == '0) begin
            ack_q.push_back('{owner, cyc + 1});
            @(negedge clk);
            cnt_done_i = 1'b0;
        end else begin
            @(negedge clk);
            cnt_done_i = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            cnt_done_i = 1'b1;
            ack_q.push_back('{owner, cyc + 1});
            @(negedge clk);
            cnt_done_i = 1'b0;
        end
        last = owner;
    endtask

    initial begin
        int           o;
        logic [N*W-1:0] v;
        job_t         j;
        repeat (2) @(negedge clk);
        check("rst_gnt", 64'(gnt_o), 64'(0));
        check("rst_ack", 64'(ack_o), 64'(0));
        check("rst_busy_start", 64'({busy_o, start_o}), 64'(0));
        check("rst_cnt_val", 64'(cnt_val_o), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            run_job(4'b1111, {8'd3, 8'd2, 8'd1, 8'd4}, 0, 1'b0, o);
            check("fair_order", 64'(o), 64'(k % 4));
        end
        run_job(4'b0100, {8'd0, 8'd5, 8'd0, 8'd0}, 0, 1'b1, o);
        check("single_req_owner", 64'(o), 64'(2));
        run_job(4'b0001, {8'd7, 8'd7, 8'd7, 8'd0}, 0, 1'b0, o);
        check("zero_target_owner", 64'(o), 64'(0));
        run_job(4'b0010, {8'd1, 8'd1, 8'd9, 8'd1}, 3, 1'b0, o);
        run_job(4'b0010, {8'd1, 8'd1, 8'd4, 8'd1}, 0, 1'b0, o);
        check("sole_regrant", 64'(o), 64'(1));
        for (int n = 0; n < 30; n++) begin
            for (int k = 0; k < N; k++)
                v[k*W +: W] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            run_job(N'($urandom_range(1, 15)), v, $urandom_range(0, 2), 1'($urandom_range(0, 1)), o);
        end
        req_i      = 4'b0100;
        cnt_val_i  = {8'd0, 8'd9, 8'd0, 8'd0};
        j.owner    = 2;
        j.val      = 8'd9;
        grant_q.push_back(j);
        repeat (3) @(negedge clk);
        check("pre_reset_wait_gnt", 64'(gnt_o), 64'(4'b0100));
        rst_n = 1'b0;
        #1;
        check("mid_reset_outputs", 64'({gnt_o, ack_o, busy_o, start_o, cnt_val_o}), 64'(0));
        last  = N - 1;
        req_i = 4'b1000;
        @(negedge clk);
        rst_n = 1'b1;
        run_job(4'b1000, {8'd6, 8'd0, 8'd0, 8'd0}, 0, 1'b0, o);
        check("post_reset_owner", 64'(o), 64'(3));
        req_i = '0;
        repeat (4) @(negedge clk);
        check("grant_q_empty", 64'(grant_q.size()), 64'(0));
        check("ack_q_empty", 64'(ack_q.size()), 64'(0));
        check("idle_at_end", 64'({busy_o, gnt_o}), 64'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
